// File: rtl/hs_req_ctrl.sv
// hs_req_ctrl: request side of a four-phase CDC handshake (IDLE -> REQ -> REL).
// Optional REQ timeout abort is compiled in by defining HS_REQ_TIMEOUT_EN.
module hs_req_ctrl #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send_valid,
  input  logic [DATA_W-1:0] send_data,
  output logic              send_ready,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_sync,
  output logic              busy,
  output logic              done_pulse,
  output logic              err_pulse
);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t            state;
  state_t            state_next;
  logic              req_next;
  logic [DATA_W-1:0] data_next;
  logic              done_next;

`ifdef HS_REQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;
  logic [15:0] count_next;
  logic        timed_out;
  logic        timed_out_next;
  logic        err_next;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign err_pulse          = 1'b0;
`endif

  // A stale acknowledge from an aborted handshake must drain before a new accept.
  assign send_ready = (state == IDLE) && !ack_sync;
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    req_next   = req_out;
    data_next  = data_out;
    done_next  = 1'b0;
`ifdef HS_REQ_TIMEOUT_EN
    count_next     = count;
    timed_out_next = timed_out;
    err_next       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (send_valid && send_ready) begin
          state_next = REQ;
          req_next   = 1'b1;
          data_next  = send_data;
`ifdef HS_REQ_TIMEOUT_EN
          count_next     = '0;
          timed_out_next = 1'b0;
`endif
        end
      end
      REQ: begin
        if (ack_sync) begin
          state_next = REL;
          req_next   = 1'b0;
        end
`ifdef HS_REQ_TIMEOUT_EN
        else if (count == TIMEOUT_LAST) begin
          state_next     = REL;
          req_next       = 1'b0;
          err_next       = 1'b1;
          timed_out_next = 1'b1;
        end else begin
          count_next = count + 16'd1;
        end
`endif
      end
      REL: begin
        // An aborted handshake still waits for ack low, but reports no completion.
        if (!ack_sync) begin
          state_next = IDLE;
`ifdef HS_REQ_TIMEOUT_EN
          done_next = !timed_out;
`else
          done_next = 1'b1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_out    <= 1'b0;
      data_out   <= '0;
      done_pulse <= 1'b0;
`ifdef HS_REQ_TIMEOUT_EN
      count      <= '0;
      timed_out  <= 1'b0;
      err_pulse  <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      req_out    <= req_next;
      data_out   <= data_next;
      done_pulse <= done_next;
`ifdef HS_REQ_TIMEOUT_EN
      count      <= count_next;
      timed_out  <= timed_out_next;
      err_pulse  <= err_next;
`endif
    end
  end

endmodule

// File: tb/tb_hs_req_ctrl.sv
// Scoreboard bench for hs_req_ctrl: randomized transfers driven by a scheduled
// far-domain responder, completions checked by an independent monitor.
module tb_hs_req_ctrl;

  localparam int TIMEOUT = 8;
`ifdef HS_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       send_valid;
  logic [7:0] send_data;
  logic       send_ready;
  logic       req_out;
  logic [7:0] data_out;
  logic       ack_sync;
  logic       busy;
  logic       done_pulse;
  logic       err_pulse;

  hs_req_ctrl #(.DATA_W(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .send_valid (send_valid),
    .send_data  (send_data),
    .send_ready (send_ready),
    .req_out    (req_out),
    .data_out   (data_out),
    .ack_sync   (ack_sync),
    .busy       (busy),
    .done_pulse (done_pulse),
    .err_pulse  (err_pulse)
  );

  typedef struct {
    logic [7:0] data;
    bit         is_err;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         vectors   = 0;
  int         miscompares = 0;
  int         cyc       = 0;
  bit         mon_en    = 1'b0;
  bit         model_busy = 1'b0;
  bit         model_req  = 1'b0;
  logic [7:0] model_data = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: per-cycle protocol view plus scoreboard pops on completion pulses.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      checkOutput("req_out", {31'b0, req_out}, {31'b0, model_req});
      checkOutput("busy", {31'b0, busy}, {31'b0, model_busy});
      checkOutput("send_ready", {31'b0, send_ready}, {31'b0, (!model_busy && !ack_sync)});
      checkOutput("data_out", {24'b0, data_out}, {24'b0, model_data});
      checkOutput("done_and_err", {31'b0, (done_pulse && err_pulse)}, 32'd0);
      if (done_pulse || err_pulse) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_pulse", {30'b0, done_pulse, err_pulse}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("pulse_kind_err", {31'b0, err_pulse}, {31'b0, e.is_err});
          checkOutput("pulse_cycle", cyc, e.cyc);
          checkOutput("pulse_data", {24'b0, data_out}, {24'b0, e.data});
        end
      end
    end
  end

  task automatic noise();
    send_valid = 1'($urandom_range(0, 1));
    send_data  = 8'($urandom);
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // One transfer: idle gap, accept, d edges with ack low, then ack high for h edges.
  task automatic applyStimulus(input logic [7:0] data, input int d, input int h, input int gap);
    int  acc;
    bit  to;
    send_valid = 1'b0;
    ack_sync   = 1'b0;
    for (int i = 0; i < gap; i++) stepEdge();
    send_valid = 1'b1;
    send_data  = data;
    stepEdge();
    acc        = cyc;
    model_busy = 1'b1;
    model_req  = 1'b1;
    model_data = data;
    to = TO_EN && (d >= TIMEOUT);
    if (to) begin
      sb.push_back('{data: data, is_err: 1'b1, cyc: acc + TIMEOUT});
      for (int k = 1; k <= TIMEOUT + 1; k++) begin
        noise();
        stepEdge();
        if (k == TIMEOUT) model_req = 1'b0;
        if (k == TIMEOUT + 1) model_busy = 1'b0;
      end
    end else begin
      sb.push_back('{data: data, is_err: 1'b0, cyc: acc + d + h + 1});
      for (int k = 1; k <= d; k++) begin
        noise();
        stepEdge();
      end
      ack_sync = 1'b1;
      noise();
      stepEdge();
      model_req = 1'b0;
      for (int k = 2; k <= h; k++) begin
        noise();
        stepEdge();
      end
      ack_sync = 1'b0;
      noise();
      stepEdge();
      model_busy = 1'b0;
    end
    send_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    send_valid = 1'b0;
    send_data  = 8'h00;
    ack_sync   = 1'b0;
    #3;
    checkOutput("rst_req_out", {31'b0, req_out}, 32'd0);
    checkOutput("rst_data_out", {24'b0, data_out}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done_pulse}, 32'd0);
    checkOutput("rst_err", {31'b0, err_pulse}, 32'd0);
    checkOutput("rst_send_ready", {31'b0, send_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Basic A5 transfer: ack rises 4 cycles after req, falls 3 cycles after req drops.
    applyStimulus(8'hA5, 4, 4, 0);
    // Back-to-back transfers with fast echo.
    applyStimulus(8'h01, 1, 1, 0);
    applyStimulus(8'h02, 1, 1, 0);
    applyStimulus(8'h5A, 0, 1, 0);
    // Timeout boundary: ack arriving on the last allowed edge, then one edge late.
    applyStimulus(8'h77, TIMEOUT - 1, 2, 1);
    applyStimulus(8'h88, TIMEOUT, 1, 1);

    // Reset mid-REQ with ack high: transfer abandoned, stale ack blocks acceptance.
    send_valid = 1'b1;
    send_data  = 8'h3C;
    stepEdge();
    model_busy = 1'b1;
    model_req  = 1'b1;
    model_data = 8'h3C;
    send_valid = 1'b0;
    ack_sync   = 1'b1;
    #2;
    rst_n      = 1'b0;
    model_busy = 1'b0;
    model_req  = 1'b0;
    model_data = 8'h00;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("stale_req_out", {31'b0, req_out}, 32'd0);
    checkOutput("stale_send_ready", {31'b0, send_ready}, 32'd0);
    send_valid = 1'b1;
    send_data  = 8'hEE;
    repeat (3) stepEdge();
    send_valid = 1'b0;
    ack_sync   = 1'b0;
    #1;
    checkOutput("drained_send_ready", {31'b0, send_ready}, 32'd1);
    repeat (3) stepEdge();

    // First accept right after the stale ack cleared.
    applyStimulus(8'hC3, 2, 1, 0);

    for (int t = 0; t < 40; t++) begin
      applyStimulus(8'($urandom), $urandom_range(0, TIMEOUT + 2),
                    $urandom_range(1, 4), $urandom_range(0, 3));
    end

    // Long wait with ack low: aborts only when the timeout is built in.
    applyStimulus(8'h96, TO_EN ? TIMEOUT + 5 : 5000, 1, 0);

    repeat (3) stepEdge();
    checkOutput("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hs_req_ctrl.md
HS_REQ_CTRL -- requirements
Module: hs_req_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, width of the transferred payload.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum cycles in REQ before abort; legal range 2..65535.
REQ-003 clk  input  1  single block clock, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 send_valid  input  1  upstream offers a payload.
REQ-006 send_data  input  DATA_W  payload offered with send_valid.
REQ-007 send_ready  output  1  block can accept a payload this cycle.
REQ-008 req_out  output  1  four-phase request toward the CDC request synchronizer.
REQ-009 data_out  output  DATA_W  registered payload, held for the far domain.
REQ-010 ack_sync  input  1  acknowledge, already synchronized into clk.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done_pulse  output  1  one-cycle pulse on handshake completion.
REQ-013 err_pulse  output  1  one-cycle pulse on timeout abort.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, REQ and REL.
REQ-015 send_ready SHALL be combinationally (state==IDLE && !ack_sync).
REQ-016 Accept: if send_valid && send_ready at edge N, data_out <= send_data, req_out <= 1 and state <= REQ at edge N.
REQ-017 While send_ready is 0, send_valid SHALL be ignored, with no capture and no state change.
REQ-018 In REQ, ack_sync sampled 1 at edge M SHALL give req_out <= 0 and state <= REL at edge M.
REQ-019 In REL, ack_sync sampled 0 at edge K SHALL give state <= IDLE and done_pulse <= 1 at edge K; done_pulse SHALL be 0 at edge K+1.
REQ-020 data_out SHALL remain stable from the accept edge until the block returns to IDLE.
REQ-021 data_out SHALL retain its last value in IDLE.
REQ-022 busy SHALL be registered-state derived: 0 in IDLE, 1 in REQ and REL.
REQ-023 A new accept SHALL be possible in the same cycle done_pulse is high.
REQ-024 Minimum round trip is 3 edges after accept (accept -> ack high -> ack low).
REQ-025 Stale ack_sync high in IDLE (for example, after a reset mid-handshake) SHALL block acceptance until ack_sync is 0.
REQ-026 ack_sync falling while in REQ before it is seen high SHALL have no effect; the block keeps waiting.
REQ-027 done_pulse and err_pulse SHALL never be high in the same cycle.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, req_out=0, data_out=0, done_pulse=0, err_pulse=0, timeout counter=0.
REQ-029 Reset during REQ or REL SHALL abort the transfer silently, with no done_pulse or err_pulse.
REQ-030 The first accept after reset release SHALL be possible at the first edge where send_valid=1 and ack_sync=0.

Configuration
REQ-031 Macro HS_REQ_TIMEOUT_EN SHALL control inclusion of the timeout feature.
REQ-032 With HS_REQ_TIMEOUT_EN defined: a 16-bit counter clears on entry to REQ and increments each cycle in REQ.
REQ-033 With HS_REQ_TIMEOUT_EN defined: if the counter equals TIMEOUT_CYCLES-1 and ack_sync is 0 at an edge, then req_out <= 0, state <= REL and err_pulse <= 1 for one cycle; a simultaneous ack_sync=1 SHALL take the normal REQ->REL path with no error.
REQ-034 With HS_REQ_TIMEOUT_EN defined: after a timeout, the REL exit to IDLE SHALL NOT assert done_pulse.
REQ-035 Without HS_REQ_TIMEOUT_EN: there is no counter, err_pulse is tied 0, and REQ waits indefinitely.

Verification
REQ-036 Reset, then send_valid=1 with send_data=8'hA5 and ack_sync=0 -> req_out=1 and data_out=A5 after the next edge; send_ready=0; busy=1.
REQ-037 ack_sync rises 4 cycles after req_out and falls 3 cycles after req_out drops -> done_pulse high exactly 1 cycle; data_out=A5 throughout; send_ready=1 in the done cycle.
REQ-038 Back-to-back: send_valid held with 8'h01 then 8'h02 and ack echoed with 1-cycle latency -> two done_pulses, payloads in order, no lost or duplicated req.
REQ-039 Assert rst_n=0 in REQ while ack_sync=1, release with ack_sync still 1 -> req_out=0 and send_ready=0; after ack_sync drops, send_ready=1 and no done_pulse.
REQ-040 HS_REQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, ack_sync held 0 -> req_out drops 8 cycles after assertion; err_pulse high 1 cycle; back in IDLE next cycle; no done_pulse.
REQ-041 HS_REQ_TIMEOUT_EN undefined, ack_sync held 0 for 5000 cycles -> req_out stays 1 and err_pulse stays 0.
